// File: rtl/configs_loader_pkg.sv
// Shared definitions for the configuration loader: the FSM state encoding,
// the default geometry, and the index-width helper.
package configs_loader_pkg;

  localparam int DEF_NUM_WORDS = 36;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_IDX_W     = $clog2(DEF_NUM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_e;

  // Width of the word index. It is never narrower than one bit, so a
  // single-word configuration still has a legal index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/configs_loader.sv
// Configuration loader. It takes config words over a valid/ready handshake
// and writes each one into a latch array. Every word goes through four
// cycles: it is captured, then held for one cycle of setup, then strobed
// with a one-hot enable, then held one more cycle. All outputs come from
// registers, so the latch array never sees a glitch on its enables.
module configs_loader
  import configs_loader_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_bits,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic [WORD_W-1:0]    io_checksum
);

  localparam int                IDX_W    = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_WORDS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_W-1:0]      d_out_q, d_out_d;
  logic [WORD_W-1:0]      chk_q, chk_d;
  logic [NUM_WORDS-1:0]   en_q, en_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state logic. Each registered output is decoded from the next
  // state, so it lines up with the state it describes.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. If any
    // path left a signal unassigned, synthesis would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    d_out_d = d_out_q;
    chk_d   = chk_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (io_start) begin
          state_d = WAIT_WORD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      WAIT_WORD: begin
        if (io_in_valid && ready_q) begin
          d_out_d = io_in_bits;
          chk_d   = chk_q ^ io_in_bits;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = WAIT_WORD;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == WAIT_WORD);
    busy_d  = state_d inside {WAIT_WORD, SETUP, STROBE, HOLD};
    done_d  = (state_d == DONE);

    // The enable decode is inline. The index does not change between
    // SETUP and STROBE, so idx_q already selects the word being strobed.
    en_d = '0;
    if (state_d == STROBE) begin
      en_d[idx_q] = 1'b1;
    end
  end

  // State and output registers. Reset is synchronous and takes priority
  // over start and over any accept in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All the
    // registers then update together at the edge, whatever order the
    // statements appear in.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      d_out_q <= '0;
      chk_q   <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_out_q <= d_out_d;
      chk_q   <= chk_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io_in_ready   = ready_q;
  assign io_d_out      = d_out_q;
  assign io_configs_en = en_q;
  assign io_busy       = busy_q;
  assign io_done       = done_q;
  assign io_checksum   = chk_q;

endmodule

// File: tb/tb_configs_loader.sv
// Testbench for configs_loader. A cycle model of the loader pushes the
// expected enable pulses into a queue. A monitor on the falling edge pops
// the queue whenever the DUT raises an enable and compares the pulse.
module tb_configs_loader;

  localparam int NW = 36;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [WW-1:0] io_in_bits;
  logic [WW-1:0] io_d_out;
  logic [NW-1:0] io_configs_en;
  logic          io_busy;
  logic          io_done;
  logic [WW-1:0] io_checksum;

  always #5 clk = ~clk;

  configs_loader #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_start     (io_start),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_d_out     (io_d_out),
    .io_configs_en(io_configs_en),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_checksum  (io_checksum)
  );

  typedef struct {
    int            k;
    logic [WW-1:0] word;
    int            strobe;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [NW-1:0] mon_onehot;
  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  bit            mon_on = 1'b0;
  string         cur_load = "reset";
  logic [NW-1:0] prev_en = '0;
  logic [WW-1:0] prev_dout = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s (cycle %0d): observed 0x%0h expected 0x%0h",
                cur_load, tag, cyc, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scoreboard monitor. Every enable pulse must match the next queued
  // expectation. The enables must also be one-hot, never on in two
  // consecutive cycles, and io_d_out must stay stable around each strobe.
  always @(negedge clk) begin
    if (mon_on) begin
      if (prev_en !== '0) check("d_out_hold_after_en", 64'(io_d_out), 64'(prev_dout));
      if (io_configs_en !== '0) begin
        check("en_onehot0", 64'($onehot0(io_configs_en)), 64'd1);
        check("en_back_to_back", 64'(prev_en), 64'd0);
        check("d_out_stable_at_en", 64'(io_d_out), 64'(prev_dout));
        if (sb_q.size() == 0) begin
          check("unexpected_en", 64'(io_configs_en), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          mon_onehot = '0;
          mon_onehot[mon_e.k] = 1'b1;
          check("en_index", 64'(io_configs_en), 64'(mon_onehot));
          check("en_d_out", 64'(io_d_out), 64'(mon_e.word));
          check("en_cycle", 64'(cyc), 64'(mon_e.strobe));
        end
      end
    end
    prev_en   = io_configs_en;
    prev_dout = io_d_out;
  end

  // Runs one load. The cycle model gives the timing: word k is offered in
  // cycle 1+4k plus any earlier gap, and is strobed two cycles after it is
  // accepted. gap_k withholds valid before word gap_k for gap_len cycles.
  // pulse_k pulses io_start during the STROBE of word pulse_k. abort_k
  // asserts reset in the SETUP of word abort_k. Pass -1 to disable each.
  task automatic run_load(input string name, input bit ones, input int gap_k,
                          input int gap_len, input int pulse_k, input int abort_k);
    logic [WW-1:0] words[NW];
    logic [WW-1:0] model_chk;
    cur_load  = name;
    model_chk = '0;
    for (int k = 0; k < NW; k++) words[k] = ones ? '1 : (32'h1000_0000 + WW'(k));

    // Cycle 0: start is sampled. Valid is already high here and must be ignored.
    io_in_valid = 1'b1;
    io_in_bits  = words[0];
    io_start    = 1'b1;
    cyc = 0;
    tick();
    io_start = 1'b0;
    check("busy_after_start", 64'(io_busy), 64'd1);
    check("done_after_start", 64'(io_done), 64'd0);
    check("chk_cleared", 64'(io_checksum), 64'd0);

    for (int k = 0; k < NW; k++) begin
      io_in_bits = words[k];
      if (k == gap_k) begin
        io_in_valid = 1'b0;
        for (int i = 0; i < gap_len; i++) begin
          check("ready_in_gap", 64'(io_in_ready), 64'd1);
          tick();
        end
        io_in_valid = 1'b1;
      end
      check("ready_wait", 64'(io_in_ready), 64'd1);
      model_chk ^= words[k];
      if (k != abort_k) sb_q.push_back('{k, words[k], cyc + 2});
      tick();  // SETUP
      check("ready_setup", 64'(io_in_ready), 64'd0);
      check("chk_running", 64'(io_checksum), 64'(model_chk));
      if (k == abort_k) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(io_busy), 64'd0);
        check("abort_done", 64'(io_done), 64'd0);
        check("abort_ready", 64'(io_in_ready), 64'd0);
        check("abort_en", 64'(io_configs_en), 64'd0);
        check("abort_d_out", 64'(io_d_out), 64'd0);
        check("abort_chk", 64'(io_checksum), 64'd0);
        repeat (6) tick();
        check("abort_stays_idle", 64'(io_busy), 64'd0);
        check("abort_no_pending", 64'(sb_q.size()), 64'd0);
        return;
      end
      tick();  // STROBE
      if (k == pulse_k) io_start = 1'b1;
      tick();  // HOLD
      io_start = 1'b0;
      check("busy_hold", 64'(io_busy), 64'd1);
      check("done_hold", 64'(io_done), 64'd0);
      tick();  // WAIT_WORD of the next word, or DONE
    end

    check("done_final", 64'(io_done), 64'd1);
    check("busy_final", 64'(io_busy), 64'd0);
    check("ready_final", 64'(io_in_ready), 64'd0);
    check("chk_final", 64'(io_checksum), 64'(model_chk));
    check("d_out_final", 64'(io_d_out), 64'(words[NW-1]));
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    io_in_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    io_start    = 1'b0;
    io_in_valid = 1'b1;
    io_in_bits  = 32'hDEAD_BEEF;
    repeat (2) tick();
    // Start is asserted while reset is still high. Reset must win.
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    check("rst_busy", 64'(io_busy), 64'd0);
    check("rst_done", 64'(io_done), 64'd0);
    check("rst_ready", 64'(io_in_ready), 64'd0);
    check("rst_en", 64'(io_configs_en), 64'd0);
    check("rst_d_out", 64'(io_d_out), 64'd0);
    check("rst_chk", 64'(io_checksum), 64'd0);
    reset = 1'b0;
    tick();
    mon_on = 1'b1;
    // Valid is high in IDLE, but no start has been given, so the loader must stay idle.
    check("idle_ignores_valid", 64'(io_busy), 64'd0);

    // Plain load: en[k] at cycle 3+4k, done at cycle 145.
    run_load("load_a", 1'b0, -1, 0, -1, -1);
    // Restart from DONE with all-ones words: the checksum ends at zero.
    run_load("load_b", 1'b1, -1, 0, -1, -1);
    check("all_ones_chk_zero", 64'(io_checksum), 64'd0);
    // Valid withheld for 10 cycles before word 5, and start pulsed in the STROBE of word 12.
    run_load("load_c", 1'b0, 5, 10, 12, -1);
    // Reset asserted in the SETUP of word 20.
    run_load("load_d", 1'b0, -1, 0, -1, 20);

    repeat (3) tick();
    cur_load = "end";
    check("end_idle_busy", 64'(io_busy), 64'd0);
    check("end_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
